// File: rtl/marc_main_memory_if.sv
// Request/ready bus and side-band preload port between the mARC processor and main memory.
interface marc_main_memory_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  req;
  logic                  rw;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
  logic                  busy;
  logic                  load_en;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [DATA_WIDTH-1:0] load_data;

  modport master (
    output req, rw, addr, wdata, load_en, load_addr, load_data,
    input  rdata, ready, busy
  );

  modport slave (
    input  req, rw, addr, wdata, load_en, load_addr, load_data,
    output rdata, ready, busy
  );
endinterface

// File: rtl/marc_main_memory.sv
// Word-addressed main memory for mARC: request/ready access with configurable wait
// states, plus a preload port that only writes while no access is in flight.
module marc_main_memory #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic               clk,
  input  logic               reset,
  marc_main_memory_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  // PEND: access latched, completes (memory read/write, ready pulse) at the next edge.
  typedef enum logic [1:0] {IDLE, WAIT, PEND} state_t;

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rw_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  complete;
  logic                  load_ok;
  logic                  wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_d;

  // A new access may be accepted on the same edge that completes the previous one;
  // completion uses the old latched values, so back-to-back streaming is safe.
  assign accept   = bus.req && (state_q != WAIT);
  assign complete = (state_q == PEND);
  assign load_ok  = bus.load_en && !bus.req && (state_q == IDLE) && !ready_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      ready_q <= complete;
      if (complete && !rw_q) rdata_q <= mem[addr_q];
      if (accept) begin
        addr_q  <= bus.addr;
        rw_q    <= bus.rw;
        wdata_q <= bus.wdata;
        if (WAIT_STATES == 0) begin
          state_q <= PEND;
        end else begin
          state_q <= WAIT;
          cnt_q   <= CNT_INIT;
        end
      end else begin
        unique case (state_q)
          WAIT: begin
            if (cnt_q == 4'd0) state_q <= PEND;
            else               cnt_q   <= cnt_q - 4'd1;
          end
          PEND:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = addr_q;
    wr_data_d = wdata_q;
    if (complete && rw_q) begin
      wr_en_d = 1'b1;
    end else if (load_ok) begin
      wr_en_d   = 1'b1;
      wr_addr_d = bus.load_addr;
      wr_data_d = bus.load_data;
    end
  end

  // NOTE: the storage array has no reset; gating with reset keeps an aborted or
  // in-reset write from landing in the array.
  always_ff @(posedge clk) begin
    if (reset && wr_en_d) mem[wr_addr_d] <= wr_data_d;
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.busy  = (state_q == WAIT);
endmodule

// File: tb/tb_marc_main_memory.sv
// Directed bench for marc_main_memory: three instances (0, 3 and 2 wait states) share one
// stimulus set, a select routes requests, and a queue scoreboard checks every ready pulse.
module tb_marc_main_memory;
  localparam int DW = 16;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int            sel;
  logic          req, rw, load_en;
  logic [AW-1:0] addr, load_addr;
  logic [DW-1:0] wdata, load_data;
  logic          ready_s, busy_s;
  logic [DW-1:0] rdata_s;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_sb;

  marc_main_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();
  marc_main_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if3 ();
  marc_main_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if2 ();

  assign if0.req       = req && (sel == 0);
  assign if0.rw        = rw;
  assign if0.addr      = addr;
  assign if0.wdata     = wdata;
  assign if0.load_en   = load_en && (sel == 0);
  assign if0.load_addr = load_addr;
  assign if0.load_data = load_data;

  assign if3.req       = req && (sel == 1);
  assign if3.rw        = rw;
  assign if3.addr      = addr;
  assign if3.wdata     = wdata;
  assign if3.load_en   = load_en && (sel == 1);
  assign if3.load_addr = load_addr;
  assign if3.load_data = load_data;

  assign if2.req       = req && (sel == 2);
  assign if2.rw        = rw;
  assign if2.addr      = addr;
  assign if2.wdata     = wdata;
  assign if2.load_en   = load_en && (sel == 2);
  assign if2.load_addr = load_addr;
  assign if2.load_data = load_data;

  assign ready_s = (sel == 0) ? if0.ready : (sel == 1) ? if3.ready : if2.ready;
  assign busy_s  = (sel == 0) ? if0.busy  : (sel == 1) ? if3.busy  : if2.busy;
  assign rdata_s = (sel == 0) ? if0.rdata : (sel == 1) ? if3.rdata : if2.rdata;

  marc_main_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(rst_n), .bus(if0.slave));
  marc_main_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(rst_n), .bus(if3.slave));
  marc_main_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .reset(rst_n), .bus(if2.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] exp);
    req   = 1'b1;
    rw    = w;
    addr  = a;
    wdata = d;
    exp_q.push_back(exp);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  // Scoreboard: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && ready_s === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", ready_s, 0);
      end else begin
        exp_sb = exp_q.pop_front();
        check("sb_rdata", rdata_s, exp_sb);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed time limit reached, expected $finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sel = 0; rst_n = 1'b0; req = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("rst_ready", ready_s, 0);
      check("rst_busy",  busy_s,  0);
      check("rst_rdata", rdata_s, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int s = 0; s < 3; s++) begin
      sel = s;
      load(8'h00, 16'h5140);
      load(8'h01, 16'h5A01);
      load(8'h20, 16'hAAAA);
    end

    // Zero wait states: ready one cycle after accept, one cycle wide.
    sel = 0;
    start(1'b0, 8'h00, 16'h0000, 16'h5140);
    @(negedge clk); req = 1'b0;
    check("ws0_ready_early", ready_s, 0);
    check("ws0_busy", busy_s, 0);
    @(negedge clk);
    check("ws0_ready_lat", ready_s, 1);
    check("ws0_rd0", rdata_s, 16'h5140);
    @(negedge clk);
    check("ws0_ready_width", ready_s, 0);
    start(1'b0, 8'h01, 16'h0000, 16'h5A01);
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    check("ws0_rd1", rdata_s, 16'h5A01);
    @(negedge clk);

    // Write then back-to-back read of the same word.
    start(1'b1, 8'h10, 16'hBEEF, 16'h5A01);
    @(negedge clk);
    start(1'b0, 8'h10, 16'h0000, 16'hBEEF);
    @(negedge clk); req = 1'b0;
    check("wr_ready", ready_s, 1);
    check("wr_rdata_hold", rdata_s, 16'h5A01);
    @(negedge clk);
    check("raw_ready", ready_s, 1);
    check("raw_rdata", rdata_s, 16'hBEEF);
    @(negedge clk);
    check("raw_ready_end", ready_s, 0);

    // Streaming with req held high: one access per cycle, busy never set.
    start(1'b0, 8'h00, 16'h0000, 16'h5140);
    @(negedge clk);
    check("stream_n1_ready", ready_s, 0);
    start(1'b0, 8'h01, 16'h0000, 16'h5A01);
    @(negedge clk);
    check("stream_r1", ready_s, 1);
    check("stream_busy1", busy_s, 0);
    start(1'b0, 8'h00, 16'h0000, 16'h5140);
    @(negedge clk); req = 1'b0;
    check("stream_r2", ready_s, 1);
    check("stream_d2", rdata_s, 16'h5A01);
    check("stream_busy2", busy_s, 0);
    @(negedge clk);
    check("stream_r3", ready_s, 1);
    check("stream_d3", rdata_s, 16'h5140);
    @(negedge clk);
    check("stream_end", ready_s, 0);

    // Request wins over a simultaneous load; the load target keeps its value.
    start(1'b0, 8'h10, 16'h0000, 16'hBEEF);
    load_en = 1'b1; load_addr = 8'h01; load_data = 16'h0BAD;
    @(negedge clk); req = 1'b0; load_en = 1'b0;
    @(negedge clk);
    check("prio_ready", ready_s, 1);
    start(1'b0, 8'h01, 16'h0000, 16'h5A01);
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    check("prio_target", rdata_s, 16'h5A01);
    @(negedge clk);

    // Three wait states: busy for three cycles, ready at accept+4, req in WAIT ignored.
    sel = 1;
    start(1'b0, 8'h00, 16'h0000, 16'h5140);
    @(negedge clk); req = 1'b0;
    check("ws3_busy1", busy_s, 1);
    @(negedge clk);
    check("ws3_busy2", busy_s, 1);
    req = 1'b1; rw = 1'b0; addr = 8'h01;
    @(negedge clk); req = 1'b0;
    check("ws3_busy3", busy_s, 1);
    @(negedge clk);
    check("ws3_busy4", busy_s, 0);
    check("ws3_ready_early", ready_s, 0);
    @(negedge clk);
    check("ws3_ready_lat", ready_s, 1);
    check("ws3_rdata", rdata_s, 16'h5140);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ws3_no_extra", ready_s, 0);
    end

    // Load strobe during WAIT must not reach the array.
    start(1'b0, 8'h01, 16'h0000, 16'h5A01);
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    load_en = 1'b1; load_addr = 8'h01; load_data = 16'hDEAD;
    @(negedge clk); load_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ws3_load_ignored", rdata_s, 16'h5A01);
    @(negedge clk);

    // Reset during a two-wait-state write: no ready, no array update.
    sel = 2;
    req = 1'b1; rw = 1'b1; addr = 8'h20; wdata = 16'h1234;
    @(negedge clk); req = 1'b0;
    check("abort_busy", busy_s, 1);
    rst_n = 1'b0;
    #1;
    check("abort_rst_busy", busy_s, 0);
    check("abort_rst_rdata", rdata_s, 0);
    @(negedge clk);
    check("abort_rst_ready", ready_s, 0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort_no_ready", ready_s, 0);
    start(1'b0, 8'h20, 16'h0000, 16'hAAAA);
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("abort_readback_ready", ready_s, 1);
    check("abort_readback", rdata_s, 16'hAAAA);
    @(negedge clk);

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/marc_main_memory.md
# marc_main_memory

Parametrised word-addressed main memory for the mARC processor. It replaces hard-wired `dataIn` stimulus with a real storage array. It serves instruction fetches and data reads/writes over a request/ready handshake, with a configurable number of wait states, and it has a side-band load port for preloading programs before the processor runs. It sits between the processor's bus A (address), bus B (write data) and `rw` outputs and its `dataIn` input.

## Interface
- `DATA_WIDTH`, default 16: word width; matches the processor data path.
- `ADDR_WIDTH`, default 8: word-address width; DEPTH = 2**ADDR_WIDTH words.
- `WAIT_STATES`, default 0: extra cycles inserted before each access completes; legal range 0..15.

- `clk` input, 1: single clock; all state changes on the rising edge.
- `reset` input, 1: asynchronous, active-low reset.
- `req` input, 1: access request; sampled only when the block can accept.
- `rw` input, 1: 1 = write, 0 = read; sampled with `req`.
- `addr` input, ADDR_WIDTH: word address; the low bits of bus A.
- `wdata` input, DATA_WIDTH: write data from bus B.
- `rdata` output, DATA_WIDTH: read data; drives processor `dataIn`.
- `ready` output, 1: one-cycle completion pulse for the accepted access.
- `busy` output, 1: high while an access is pending; requests are ignored when high.
- `load_en` input, 1: preload write strobe.
- `load_addr` input, ADDR_WIDTH: preload address.
- `load_data` input, DATA_WIDTH: preload data.

## Operation
- FSM states:
  - IDLE: no access pending.
  - WAIT: counting wait states.
  - RESP: `ready` high; lasts exactly one cycle.
- Accept condition:
  - `req`=1 at a rising edge while the state is IDLE or RESP.
  - `addr`, `rw` and `wdata` are latched into internal registers at that edge.
- After accept:
  - WAIT_STATES=0: go to RESP.
  - Otherwise: go to WAIT with counter = WAIT_STATES-1.
- WAIT: counter decrements each edge; at 0, go to RESP.
- Completion (edge entering RESP):
  - Read: `rdata` <= mem[latched addr].
  - Write: mem[latched addr] <= latched wdata; `rdata` is unchanged.
- RESP exit: with `req`=1, accept the new access (back-to-back); otherwise go to IDLE.
- `rdata` holds its value until the next read completes.
- `busy` = (state == WAIT) or (access accepted but not yet completed); it is 0 in IDLE and RESP.
- `req` while in WAIT is ignored; it is neither queued nor reported as an error.
- Load port:
  - `load_en`=1 in IDLE with `req`=0 writes mem[load_addr] <= load_data at that edge.
  - `load_en` is ignored in any other state or when `req`=1; `req` has priority.
- Read-after-write to the same address in consecutive accesses returns the newly written data.
- No out-of-range case: the full ADDR_WIDTH space is populated.

## Timing
- Reset values: state IDLE, `ready`=0, `busy`=0, `rdata`=0, wait counter 0.
- Memory array contents are NOT cleared by reset.
- Reset asserted mid-access:
  - Immediate return to the reset values.
  - A pending write is discarded, with no array update.
  - `ready` never pulses for the aborted access.
- Latency: accept at edge k gives `ready`=1 (and `rdata` valid for reads) after edge k+1+WAIT_STATES, for one cycle.
- Throughput: one access per WAIT_STATES+1 cycles with `req` held high.
- WAIT_STATES=0 gives one access per cycle; `busy` stays 0 throughout.
- `req` may be held high continuously; each acceptance edge starts one access.
- `rdata` and `ready` are registered outputs with no combinational path from the inputs.

## Test plan
- Reset and readback:
  - Assert `reset`=0, release, `load_en` 0x5140 @0, 0x5A01 @1.
  - Read @0 with WAIT_STATES=0 -> `rdata`=0x5140 and `ready` pulse exactly 1 cycle after accept.
  - Read @1 -> 0x5A01.
- Wait states:
  - WAIT_STATES=3, read @0 -> `busy`=1 for 3 cycles, `ready` at accept+4, `rdata`=0x5140.
  - `req` pulsed during WAIT -> ignored, no extra `ready`.
- Write then read:
  - Write 0xBEEF @0x10, then back-to-back read @0x10 -> `rdata`=0xBEEF.
  - `rdata` unchanged during the write's completion cycle.
- Streaming:
  - WAIT_STATES=0, `req` held high, reads @0,@1,@0 -> `ready` high 3 consecutive cycles, `rdata` 0x5140, 0x5A01, 0x5140.
- Reset mid-access:
  - WAIT_STATES=2, write 0x1234 @0x20 over existing 0xAAAA.
  - `reset`=0 one cycle after accept -> no `ready`, `rdata`=0.
  - Subsequent read @0x20 -> 0xAAAA.
- Load-port priority:
  - `load_en` with `req` in the same IDLE cycle -> the access proceeds and the load target is unchanged.
  - `load_en` during WAIT -> ignored.
